icache_assoc: RTL and testbench
===============================

ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 Parameter s_offset, default 5, byte-offset bits; line is 2**s_offset bytes (256 bits at default).
REQ-002 Parameter s_index, default 3, set-index bits; 2**s_index sets.
REQ-003 Parameter num_ways, default 4, associativity; power of two, 1..8.
REQ-004 Derived s_tag = 32 - s_offset - s_index; not overridable.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 mem_address  input  32  CPU fetch address; held stable from mem_read assertion until mem_resp.
REQ-008 mem_read  input  1  CPU fetch request.
REQ-009 mem_rdata256  output  cacheline_t  line containing mem_address; valid when mem_resp=1.
REQ-010 mem_resp  output  1  one-cycle completion pulse.
REQ-011 pmem_address  output  32  {mem_address[31:s_offset], s_offset zeros}.
REQ-012 pmem_read  output  1  line-fill request to memory.
REQ-013 pmem_rdata  input  cacheline_t  fill data; valid when pmem_resp=1.
REQ-014 pmem_resp  input  1  fill completion pulse.

Function
REQ-015 Set index SHALL be mem_address[s_offset+s_index-1:s_offset]; tag SHALL be mem_address[31:s_offset+s_index].
REQ-016 Arrays SHALL be flip-flop based with combinational read; per way: data, tag, valid.
REQ-017 Hit SHALL be asserted when any way of the indexed set is valid with a matching tag; at most one way matches.
REQ-018 FSM states: IDLE, FILL.
REQ-019 IDLE, mem_read=1, hit: mem_resp=1 and mem_rdata256=hit-way data in the same cycle (0-cycle hit latency); state stays IDLE.
REQ-020 IDLE, mem_read=1, miss: next state FILL; mem_resp=0.
REQ-021 FILL: pmem_read=1 every cycle until pmem_resp=1.
REQ-022 FILL with pmem_resp=1: write pmem_rdata, tag and valid=1 into the victim way at the edge; mem_resp=1 and mem_rdata256=pmem_rdata in the same cycle; next state IDLE.
REQ-023 Victim SHALL be the lowest-numbered invalid way; if all ways are valid, the tree-PLRU way.
REQ-024 PLRU state (num_ways-1 bits per set) SHALL be updated to mark the accessed way most-recent on every hit response and every fill.
REQ-025 mem_read=0 in IDLE: no array or PLRU update, mem_resp=0, pmem_read=0.
REQ-026 num_ways=1: victim is always way 0; PLRU logic is absent.
REQ-027 pmem_read SHALL never be asserted in IDLE.

Reset
REQ-028 rst=1 SHALL clear every valid bit and PLRU bit and force state IDLE at the next edge; data and tag arrays are not cleared.
REQ-029 Outputs during and after reset: mem_resp=0, pmem_read=0.
REQ-030 rst during FILL SHALL abandon the fill with no array write, including when pmem_resp=1 in the same cycle.

Configuration
REQ-031 Macro ICACHE_PERF_CNT_EN defined: 32-bit outputs hit_count and miss_count count hit responses and IDLE-to-FILL transitions respectively; both clear on rst and wrap at 2**32.
REQ-032 Macro undefined: hit_count and miss_count ports and counters do not exist; all other behaviour is identical.

Structure
REQ-033 cacheline_t SHALL stay in rv32i_types; add ICACHE_S_OFFSET, ICACHE_S_INDEX and ICACHE_NUM_WAYS default constants there, and define the FSM state enum there.
REQ-034 Tree-PLRU storage, update and victim selection SHALL be a sub-module icache_plru, parametrised by s_index and num_ways.
REQ-035 FSM and datapath SHALL reside in icache_assoc; no separate control module.

Verification
REQ-036 After reset, read 0x0000_1000: FILL, pmem_address=0x0000_1000, pmem_resp after 3 cycles -> mem_resp in the pmem_resp cycle, data matches the fill; repeat read -> hit with mem_resp in cycle 0.
REQ-037 Defaults: fill 0x000, 0x100, 0x200 and 0x300 (all set 0), then re-read 0x000 and read 0x400 -> victim is the way holding 0x100; a later read of 0x100 misses.
REQ-038 Assert rst in the second FILL cycle while pmem_resp=1 -> no valid bit set, state IDLE, next read of the same address misses.
REQ-039 Hold pmem_resp low for 20 cycles -> pmem_read stays high throughout, mem_resp stays 0.
REQ-040 With ICACHE_PERF_CNT_EN: 2 misses and 5 hits -> miss_count=2, hit_count=5; rst -> both 0.
REQ-041 num_ways=1, s_index=4: 0x0000 and 0x0200 alternate -> every access misses; each miss overwrites way 0 of set 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types plus the instruction-cache defaults and FSM state encoding.
package rv32i_types;

    typedef logic [255:0] cacheline_t;

    localparam int ICACHE_S_OFFSET = 5;
    localparam int ICACHE_S_INDEX  = 3;
    localparam int ICACHE_NUM_WAYS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU: storage, most-recent update and victim selection.
// Level l of the tree is steered by way-index bit l (LSB at the root).
module icache_plru
    import rv32i_types::*;
#(
    parameter int s_index  = ICACHE_S_INDEX,
    parameter int num_ways = ICACHE_NUM_WAYS,
    localparam int way_w   = (num_ways > 1) ? $clog2(num_ways) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_index-1:0] set_idx,
    input  logic               touch_en,
    input  logic [way_w-1:0]   touch_way,
    output logic [way_w-1:0]   plru_way
);

    generate
        if (num_ways > 1) begin : g_tree
            localparam int num_sets = 2 ** s_index;
            localparam int levels   = $clog2(num_ways);

            // A node bit points toward the less recently used subtree.
            logic [num_ways-2:0] tree_q [num_sets];
            logic [num_ways-2:0] cur_tree;
            logic [num_ways-2:0] next_tree;

            assign cur_tree = tree_q[set_idx];

            // NOTE: every output of a combinational block is assigned a default
            // before any branch or loop so no path can leave it holding a value.
            always_comb begin
                int node;
                plru_way = '0;
                node     = 0;
                for (int l = 0; l < levels; l++) begin
                    plru_way[l] = cur_tree[node];
                    node        = 2 * node + 1 + int'(cur_tree[node]);
                end
            end

            always_comb begin
                int node;
                next_tree = cur_tree;
                node      = 0;
                for (int l = 0; l < levels; l++) begin
                    next_tree[node] = ~touch_way[l];
                    node            = 2 * node + 1 + int'(touch_way[l]);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < num_sets; s++) begin
                        tree_q[s] <= '0;
                    end
                end else if (touch_en) begin
                    tree_q[set_idx] <= next_tree;
                end
            end
        end else begin : g_direct
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, set_idx, touch_en, touch_way};
            assign plru_way      = '0;
        end
    endgenerate

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache, zero-cycle hit, single outstanding line fill.
// Optional ICACHE_PERF_CNT_EN adds hit_count / miss_count outputs.
module icache_assoc
    import rv32i_types::*;
#(
    parameter int s_offset = ICACHE_S_OFFSET,
    parameter int s_index  = ICACHE_S_INDEX,
    parameter int num_ways = ICACHE_NUM_WAYS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    output cacheline_t  mem_rdata256,
    output logic        mem_resp,
    output logic [31:0] pmem_address,
    output logic        pmem_read,
    input  cacheline_t  pmem_rdata,
    input  logic        pmem_resp
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int s_tag    = 32 - s_offset - s_index;
    localparam int num_sets = 2 ** s_index;
    localparam int way_w    = (num_ways > 1) ? $clog2(num_ways) : 1;

    icache_state_t state;

    logic [s_index-1:0] set_idx;
    logic [s_tag-1:0]   tag;
    logic               unused_offset;

    assign set_idx       = mem_address[s_offset+s_index-1:s_offset];
    assign tag           = mem_address[31:s_offset+s_index];
    assign unused_offset = ^mem_address[s_offset-1:0];

    cacheline_t         data_q  [num_sets][num_ways];
    logic [s_tag-1:0]   tag_q   [num_sets][num_ways];
    logic [num_ways-1:0] valid_q [num_sets];

    logic             hit;
    logic [way_w-1:0] hit_way;
    cacheline_t       hit_data;

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag)) begin
                hit      = 1'b1;
                hit_way  = way_w'(w);
                hit_data = data_q[set_idx][w];
            end
        end
    end

    logic [way_w-1:0] plru_way;
    logic [way_w-1:0] victim_way;

    // Descending scan leaves the lowest-numbered invalid way; PLRU only when the set is full.
    always_comb begin
        victim_way = plru_way;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) begin
                victim_way = way_w'(w);
            end
        end
    end

    logic hit_resp;
    logic fill_resp;
    logic miss_start;

    assign hit_resp     = !rst && (state == IDLE) && mem_read && hit;
    assign miss_start   = (state == IDLE) && mem_read && !hit;
    assign fill_resp    = !rst && (state == FILL) && pmem_resp;

    assign mem_resp     = hit_resp || fill_resp;
    assign mem_rdata256 = (state == FILL) ? pmem_rdata : hit_data;
    assign pmem_read    = !rst && (state == FILL);
    assign pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};

    icache_plru #(
        .s_index  (s_index),
        .num_ways (num_ways)
    ) u_plru (
        .clk       (clk),
        .rst       (rst),
        .set_idx   (set_idx),
        .touch_en  (hit_resp || fill_resp),
        .touch_way (fill_resp ? victim_way : hit_way),
        .plru_way  (plru_way)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (miss_start) state <= FILL;
                FILL: if (pmem_resp) begin
                    state                       <= IDLE;
                    valid_q[set_idx][victim_way] <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: data and tag arrays carry no reset; the valid bits alone decide
    // whether their contents are meaningful.
    always_ff @(posedge clk) begin
        if (fill_resp) begin
            data_q[set_idx][victim_way] <= pmem_rdata;
            tag_q[set_idx][victim_way]  <= tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_resp)   hit_count  <= hit_count + 32'd1;
            if (miss_start) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: timestamp-based tree-PLRU reference model,
// random and directed reads, plus a direct-mapped instance for the one-way case.
`timescale 1ns/1ps
module tb_icache_assoc;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] mem_address;
    logic        mem_read;
    cacheline_t  mem_rdata256;
    logic        mem_resp;
    logic [31:0] pmem_address;
    logic        pmem_read;
    cacheline_t  pmem_rdata;
    logic        pmem_resp;

    logic [31:0] m1_address;
    logic        m1_read;
    cacheline_t  m1_rdata;
    logic        m1_resp;
    logic [31:0] m1_pmem_address;
    logic        m1_pmem_read;
    cacheline_t  m1_pmem_rdata;
    logic        m1_pmem_resp;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count, hit_count1, miss_count1;
`endif

    icache_assoc dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_rdata256 (mem_rdata256),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    icache_assoc #(.s_offset(5), .s_index(4), .num_ways(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (m1_address),
        .mem_read     (m1_read),
        .mem_rdata256 (m1_rdata),
        .mem_resp     (m1_resp),
        .pmem_address (m1_pmem_address),
        .pmem_read    (m1_pmem_read),
        .pmem_rdata   (m1_pmem_rdata),
        .pmem_resp    (m1_pmem_resp)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count    (hit_count1),
        .miss_count   (miss_count1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: every line's contents are a fixed hash of its line address.
    function automatic cacheline_t mem_line(input logic [31:0] a);
        cacheline_t  l;
        logic [31:0] base;
        base = {a[31:5], 5'b0};
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = (base ^ 32'h5A5A_0000) * 32'h9E37_79B1 + 32'(i) * 32'h85EB_CA77;
        end
        return l;
    endfunction

    // Reference model: per-way valid/tag plus last-access time. Tree-PLRU victim is
    // found by descending into the subtree whose newest access is older.
    localparam int NS = 8;
    localparam int NW = 4;
    bit          m_valid [NS][NW];
    int unsigned m_tag   [NS][NW];
    int unsigned m_ts    [NS][NW];
    int unsigned m_time;
    int          m_hits;
    int          m_misses;

    function automatic void model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_ts[s][w]    = 0;
            end
        m_time   = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic int model_victim(input int s);
        int          prefix;
        int unsigned max0, max1;
        for (int w = 0; w < NW; w++) if (!m_valid[s][w]) return w;
        prefix = 0;
        for (int l = 0; (1 << l) < NW; l++) begin
            max0 = 0;
            max1 = 0;
            for (int w = 0; w < NW; w++) begin
                if ((w & ((1 << l) - 1)) == prefix) begin
                    if (((w >> l) & 1) == 1) max1 = (m_ts[s][w] > max1) ? m_ts[s][w] : max1;
                    else                     max0 = (m_ts[s][w] > max0) ? m_ts[s][w] : max0;
                end
            end
            if (max1 < max0) prefix = prefix | (1 << l);
        end
        return prefix;
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        int          s;
        int unsigned t;
        int          way;
        bit          h;
        s   = int'(a[7:5]);
        t   = 32'(a[31:8]);
        h   = 1'b0;
        way = 0;
        for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) begin
            h   = 1'b1;
            way = w;
        end
        if (!h) begin
            way            = model_victim(s);
            m_valid[s][way] = 1'b1;
            m_tag[s][way]   = t;
            m_misses++;
        end else begin
            m_hits++;
        end
        m_time++;
        m_ts[s][way] = m_time;
        return h;
    endfunction

    typedef struct {
        cacheline_t data;
        bit         hit;
        int         age;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] cur_addr;
    int          lat;
    bit          auto_resp;
    int          wait_cnt;

    // Memory responder: answers a fill after `lat` cycles of pmem_read.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        wait_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!auto_resp) continue;
            pmem_resp = 1'b0;
            if (pmem_read) begin
                if (wait_cnt >= lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem_line(cur_addr);
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every mem_resp; age counts cycles since the request.
    int age = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_mem_resp", 256'(mem_resp), 256'(0));
            check("rst_pmem_read", 256'(pmem_read), 256'(0));
            age = 0;
        end else begin
            if (pmem_read)
                check("pmem_address", 256'(pmem_address), 256'({cur_addr[31:5], 5'b0}));
            if (mem_resp) begin
                if (!mem_read || exp_q.size() == 0) begin
                    check("unexpected_resp", 256'(mem_resp), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", mem_rdata256, e.data);
                    check("resp_latency", 256'(age), 256'(e.age));
                    if (!e.hit) check("fill_resp_with_pmem_resp", 256'(pmem_resp), 256'(1));
                end
                age = 0;
            end else if (mem_read) begin
                if (age == 0) check("pmem_read_in_idle", 256'(pmem_read), 256'(0));
                else if (exp_q.size() > 0 && !exp_q[0].hit)
                    check("pmem_read_in_fill", 256'(pmem_read), 256'(1));
                age++;
            end else begin
                check("pmem_read_no_request", 256'(pmem_read), 256'(0));
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input int l);
        exp_t e;
        bit   h;
        bit   got;
        @(posedge clk);
        #1;
        lat    = l;
        h      = model_access(a);
        e.data = mem_line(a);
        e.hit  = h;
        e.age  = h ? 0 : l + 1;
        exp_q.push_back(e);
        cur_addr    = a;
        mem_address = a;
        mem_read    = 1'b1;
        got         = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = mem_resp;
        end
        if (!got) begin
            check("resp_timeout", 256'(got), 256'(1));
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
`ifdef ICACHE_PERF_CNT_EN
        check("hit_count_after_rst", 256'(hit_count), 256'(0));
        check("miss_count_after_rst", 256'(miss_count), 256'(0));
`endif
    endtask

    task automatic one_way_read(input logic [31:0] a);
        @(posedge clk);
        #1;
        m1_address = a;
        m1_read    = 1'b1;
        @(negedge clk);
        check("w1_no_resp_on_miss", 256'(m1_resp), 256'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("w1_pmem_read", 256'(m1_pmem_read), 256'(1));
        check("w1_pmem_address", 256'(m1_pmem_address), 256'({a[31:5], 5'b0}));
        @(posedge clk);
        #1;
        m1_pmem_resp  = 1'b1;
        m1_pmem_rdata = mem_line(a);
        @(negedge clk);
        check("w1_fill_resp", 256'(m1_resp), 256'(1));
        check("w1_fill_data", m1_rdata, mem_line(a));
        @(posedge clk);
        #1;
        m1_read      = 1'b0;
        m1_pmem_resp = 1'b0;
    endtask

    logic [23:0] tag_pool [6];

    initial begin
        logic [31:0] a;
        rst           = 1'b1;
        mem_read      = 1'b0;
        mem_address   = '0;
        cur_addr      = '0;
        auto_resp     = 1'b1;
        lat           = 0;
        m1_address    = '0;
        m1_read       = 1'b0;
        m1_pmem_resp  = 1'b0;
        m1_pmem_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // First fill of 0x1000 after reset, then the same line hits in cycle 0.
        do_read(32'h0000_1000, 3);
        do_read(32'h0000_1004, 3);

        // Fill all four ways of set 0, touch 0x000, then evict and revisit.
        do_reset();
        do_read(32'h0000_0000, 1);
        do_read(32'h0000_0100, 2);
        do_read(32'h0000_0200, 0);
        do_read(32'h0000_0300, 1);
        do_read(32'h0000_0000, 0);
        do_read(32'h0000_0400, 2);
        do_read(32'h0000_0100, 1);
        do_read(32'h0000_0000, 0);
        do_read(32'h0000_0400, 0);

        // Slow memory: pmem_read must hold for the whole wait.
        do_read(32'h0000_2020, 20);

        // Reset landing on the fill-response cycle abandons the fill.
        do_reset();
        auto_resp = 1'b0;
        @(posedge clk);
        #1;
        cur_addr    = 32'h0000_3040;
        mem_address = 32'h0000_3040;
        mem_read    = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = mem_line(32'h0000_3040);
        rst        = 1'b1;
        @(negedge clk);
        check("rst_over_fill_resp", 256'(mem_resp), 256'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pmem_resp = 1'b0;
        mem_read  = 1'b0;
        model_reset();
        wait_cnt  = 0;
        auto_resp = 1'b1;
        do_read(32'h0000_3040, 2);

        // Two misses and five hits from a clean start.
        do_reset();
        do_read(32'h0000_5000, 1);
        do_read(32'h0000_5004, 0);
        do_read(32'h0000_5008, 0);
        do_read(32'h0000_500C, 0);
        do_read(32'h0000_6000, 0);
        do_read(32'h0000_6010, 0);
        do_read(32'h0000_6014, 0);
`ifdef ICACHE_PERF_CNT_EN
        check("hit_count", 256'(hit_count), 256'(5));
        check("miss_count", 256'(miss_count), 256'(2));
`endif

        // Random traffic over a small tag pool so sets overflow and PLRU is exercised.
        do_reset();
        for (int i = 0; i < 6; i++) tag_pool[i] = 24'($urandom);
        for (int n = 0; n < 150; n++) begin
            a = {tag_pool[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            do_read(a, int'($urandom_range(0, 3)));
        end
`ifdef ICACHE_PERF_CNT_EN
        check("rand_hit_count", 256'(hit_count), 256'(m_hits));
        check("rand_miss_count", 256'(miss_count), 256'(m_misses));
        do_reset();
`endif

        // Direct-mapped instance: 0x0000 and 0x0200 share set 0 and evict each other.
        one_way_read(32'h0000_0000);
        one_way_read(32'h0000_0200);
        one_way_read(32'h0000_0000);
        one_way_read(32'h0000_0200);
        @(posedge clk);
        #1;
        m1_address = 32'h0000_0208;
        m1_read    = 1'b1;
        @(negedge clk);
        check("w1_hit_resp", 256'(m1_resp), 256'(1));
        check("w1_hit_data", m1_rdata, mem_line(32'h0000_0200));
        @(posedge clk);
        #1;
        m1_read = 1'b0;

        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
